// File: rtl/ycbcr_da_scheduler.sv
// RGB to YCbCr converter that time-shares one bit-serial shift-add multiplier
// across all nine coefficient products, then rounds and clamps each channel.
module ycbcr_da_scheduler #(
  parameter int INPUT_WIDTH        = 8,
  parameter int COEF_WIDTH         = 16,
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int SCALE              = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] r_in,
  input  logic [INPUT_WIDTH-1:0] g_in,
  input  logic [INPUT_WIDTH-1:0] b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] y_out,
  output logic [INPUT_WIDTH-1:0] cb_out,
  output logic [INPUT_WIDTH-1:0] cr_out,
  output logic                   busy
);

  localparam int PROD_W = INPUT_WIDTH + COEF_WIDTH;
  localparam int CNT_W  = $clog2(INPUT_WIDTH + 1);
  localparam logic signed [FIXED_POINT_LENGTH-1:0] CHROMA_OFS =
    FIXED_POINT_LENGTH'(128) << SCALE;
  localparam logic signed [FIXED_POINT_LENGTH-1:0] HALF =
    FIXED_POINT_LENGTH'(1) << (SCALE - 1);
  localparam logic signed [FIXED_POINT_LENGTH-1:0] PIX_MAX =
    FIXED_POINT_LENGTH'((1 << INPUT_WIDTH) - 1);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, FINAL, OUT} state_t;

  state_t                                 state, state_nxt;
  logic        [INPUT_WIDTH-1:0]          r_lat, g_lat, b_lat;
  logic        [INPUT_WIDTH-1:0]          shreg;
  logic        [PROD_W-1:0]               prod;
  logic        [CNT_W-1:0]                bitcnt;
  logic        [3:0]                      term;
  logic signed [FIXED_POINT_LENGTH-1:0]   acc_y, acc_cb, acc_cr;

  logic        [COEF_WIDTH-1:0]           term_coef;
  logic        [1:0]                      term_sel;
  logic                                   term_neg;
  logic        [1:0]                      term_ch;
  logic        [INPUT_WIDTH-1:0]          comp;
  logic signed [FIXED_POINT_LENGTH-1:0]   prod_ext;

  function automatic logic [INPUT_WIDTH-1:0] round_clamp(
    input logic signed [FIXED_POINT_LENGTH-1:0] acc
  );
    logic signed [FIXED_POINT_LENGTH-1:0] rnd;
    rnd = (acc + HALF) >>> SCALE;
    if (rnd[FIXED_POINT_LENGTH-1])
      round_clamp = '0;
    else if (rnd > PIX_MAX)
      round_clamp = '1;
    else
      round_clamp = rnd[INPUT_WIDTH-1:0];
  endfunction

  // Term table: source component (0=R,1=G,2=B), coefficient, sign, channel (0=Y,1=Cb,2=Cr)
  always_comb begin
    term_coef = '0;
    term_sel  = 2'd0;
    term_neg  = 1'b0;
    term_ch   = 2'd0;
    case (term)
      4'd0: begin term_sel = 2'd0; term_coef = COEF_WIDTH'(19595); term_neg = 1'b0; term_ch = 2'd0; end
      4'd1: begin term_sel = 2'd1; term_coef = COEF_WIDTH'(38469); term_neg = 1'b0; term_ch = 2'd0; end
      4'd2: begin term_sel = 2'd2; term_coef = COEF_WIDTH'(7471);  term_neg = 1'b0; term_ch = 2'd0; end
      4'd3: begin term_sel = 2'd0; term_coef = COEF_WIDTH'(11055); term_neg = 1'b1; term_ch = 2'd1; end
      4'd4: begin term_sel = 2'd1; term_coef = COEF_WIDTH'(21709); term_neg = 1'b1; term_ch = 2'd1; end
      4'd5: begin term_sel = 2'd2; term_coef = COEF_WIDTH'(32768); term_neg = 1'b0; term_ch = 2'd1; end
      4'd6: begin term_sel = 2'd0; term_coef = COEF_WIDTH'(32768); term_neg = 1'b0; term_ch = 2'd2; end
      4'd7: begin term_sel = 2'd1; term_coef = COEF_WIDTH'(27429); term_neg = 1'b1; term_ch = 2'd2; end
      4'd8: begin term_sel = 2'd2; term_coef = COEF_WIDTH'(5326);  term_neg = 1'b1; term_ch = 2'd2; end
      default: ;
    endcase
    case (term_sel)
      2'd0:    comp = r_lat;
      2'd1:    comp = g_lat;
      default: comp = b_lat;
    endcase
    prod_ext = signed'({{(FIXED_POINT_LENGTH-PROD_W){1'b0}}, prod});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = LOAD;
      LOAD:    state_nxt = MUL;
      MUL:     if (bitcnt == CNT_W'(INPUT_WIDTH - 1)) state_nxt = ACC;
      ACC:     state_nxt = (term == 4'd8) ? FINAL : LOAD;
      FINAL:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      r_lat     <= '0;
      g_lat     <= '0;
      b_lat     <= '0;
      shreg     <= '0;
      prod      <= '0;
      bitcnt    <= '0;
      term      <= '0;
      acc_y     <= '0;
      acc_cb    <= '0;
      acc_cr    <= '0;
      y_out     <= '0;
      cb_out    <= '0;
      cr_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          r_lat  <= r_in;
          g_lat  <= g_in;
          b_lat  <= b_in;
          acc_y  <= '0;
          acc_cb <= CHROMA_OFS;
          acc_cr <= CHROMA_OFS;
          term   <= '0;
        end
        LOAD: begin
          shreg  <= comp;
          prod   <= '0;
          bitcnt <= '0;
        end
        // One multiplier bit per cycle; zero components still take the full count
        MUL: begin
          if (shreg[0]) prod <= prod + (PROD_W'(term_coef) << bitcnt);
          shreg  <= shreg >> 1;
          bitcnt <= bitcnt + CNT_W'(1);
        end
        ACC: begin
          case (term_ch)
            2'd0:    acc_y  <= term_neg ? acc_y  - prod_ext : acc_y  + prod_ext;
            2'd1:    acc_cb <= term_neg ? acc_cb - prod_ext : acc_cb + prod_ext;
            default: acc_cr <= term_neg ? acc_cr - prod_ext : acc_cr + prod_ext;
          endcase
          if (term != 4'd8) term <= term + 4'd1;
        end
        FINAL: begin
          y_out     <= round_clamp(acc_y);
          cb_out    <= round_clamp(acc_cb);
          cr_out    <= round_clamp(acc_cr);
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ycbcr_da_scheduler.sv
// Scoreboard bench for ycbcr_da_scheduler: directed corner pixels, reset abort,
// backpressure hold and a random back-to-back stream with latency/interval tracking.
module tb_ycbcr_da_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] r_in, g_in, b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y_out, cb_out, cr_out;
  logic       busy;

  ycbcr_da_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .cb_out    (cb_out),
    .cr_out    (cr_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          acc_q[$];
  logic [23:0] exp_q[$];
  bit          meas_int = 1'b0;
  int          last_acc = -1;
  logic        prev_ov = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rc(input int v);
    int t;
    t = (v + 32768) >>> 16;
    if (t < 0) return 0;
    if (t > 255) return 255;
    return t;
  endfunction

  function automatic logic [23:0] model(input int r, input int g, input int b);
    int y, cb, cr;
    logic [7:0] y8, cb8, cr8;
    y  = 19595 * r + 38469 * g + 7471 * b;
    cb = (128 << 16) - 11055 * r - 21709 * g + 32768 * b;
    cr = (128 << 16) + 32768 * r - 27429 * g - 5326 * b;
    y8  = 8'(rc(y));
    cb8 = 8'(rc(cb));
    cr8 = 8'(rc(cr));
    return {y8, cb8, cr8};
  endfunction

  // Acceptance log for latency and pixel-to-pixel interval
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) begin
      acc_q.push_back(cyc);
      if (meas_int && last_acc >= 0) check_val("interval", cyc - last_acc, 93);
      last_acc <= cyc;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    logic [23:0] e;
    if (out_valid && !prev_ov) begin
      if (acc_q.size() > 0) check_val("latency", cyc - acc_q.pop_front() - 1, 91);
      else check_val("spurious_valid", 1, 0);
    end
    prev_ov <= out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("y", y_out, e[23:16]);
        check_val("cb", cb_out, e[15:8]);
        check_val("cr", cr_out, e[7:0]);
      end else begin
        check_val("unexpected_out", 1, 0);
      end
    end
  end

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [23:0] e);
    int n = 0;
    r_in = r; g_in = g; b_in = b; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check_val("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || out_valid) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy || out_valid) check_val("idle_timeout", busy, 0);
  endtask

  initial begin
    logic [7:0] hy, hcb, hcr;
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    r_in = '0; g_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_y", y_out, 0);
    check_val("rst_cb", cb_out, 0);
    check_val("rst_cr", cr_out, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_busy", busy, 0);

    send_pixel(8'd0, 8'd0, 8'd0, {8'd0, 8'd128, 8'd128});
    wait_idle();
    send_pixel(8'd255, 8'd255, 8'd255, {8'd255, 8'd128, 8'd128});
    wait_idle();
    send_pixel(8'd255, 8'd0, 8'd0, {8'd76, 8'd85, 8'd255});
    wait_idle();
    send_pixel(8'd0, 8'd0, 8'd255, {8'd29, 8'd255, 8'd107});
    wait_idle();

    // Abort a conversion part-way through
    send_pixel(8'd10, 8'd200, 8'd30, model(10, 200, 30));
    repeat (39) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    check_val("abort_busy", busy, 0);
    check_val("abort_in_ready", in_ready, 1);
    check_val("abort_out_valid", out_valid, 0);
    send_pixel(8'd100, 8'd50, 8'd25, model(100, 50, 25));
    wait_idle();

    // Backpressure with a second pixel waiting the whole time
    out_ready = 1'b0;
    send_pixel(8'd200, 8'd100, 8'd50, model(200, 100, 50));
    r_in = 8'd12; g_in = 8'd34; b_in = 8'd56; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("bp_out_valid", out_valid, 1);
    hy = y_out; hcb = cb_out; hcr = cr_out;
    repeat (20) begin
      @(posedge clk); #1;
      check_val("bp_hold_valid", out_valid, 1);
      check_val("bp_hold_y", y_out, hy);
      check_val("bp_hold_cb", cb_out, hcb);
      check_val("bp_hold_cr", cr_out, hcr);
      check_val("bp_in_ready", in_ready, 0);
    end
    check_val("bp_no_capture", acc_q.size(), 0);
    check_val("bp_pending", exp_q.size(), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_idle", in_ready, 1);
    check_val("bp_release_valid", out_valid, 0);
    @(posedge clk); #1;
    check_val("bp_second_accept", busy, 1);
    in_valid = 1'b0;
    exp_q.push_back(model(12, 34, 56));
    wait_idle();

    // Random back-to-back stream
    last_acc = -1;
    meas_int = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] r, g, b;
      r = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send_pixel(r, g, b, model(r, g, b));
    end
    wait_idle();
    meas_int = 1'b0;
    check_val("drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
